// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: shares one BRAM port between NREQ requesters.
// Round-robin arbitration with a combinational grant. The BRAM port controls
// are registered. Read data returns two cycles after accept, tagged with a
// one-hot rvalid. An accepted access whose address is >= MEM_SIZE is dropped,
// and err pulses for it instead.
// Optional macro BRAM_ARB_BURST_LOCK_EN: the current winner keeps priority for
// up to MAX_BURST consecutive accepts. After that it rotates to lowest priority.
module bram_port_arbiter #(
  parameter int NREQ      = 4,
  parameter int DWIDTH    = 8,
  parameter int AWIDTH    = 12,
  parameter int MEM_SIZE  = 3840,
  parameter int MAX_BURST = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          we_in,
  input  logic [NREQ*AWIDTH-1:0]   addr_in,
  input  logic [NREQ*DWIDTH-1:0]   d_in,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          rvalid,
  output logic [DWIDTH-1:0]        rdata,
  output logic [NREQ-1:0]          err,
  output logic [AWIDTH-1:0]        bram_addr,
  output logic                     bram_ce,
  output logic                     bram_we,
  output logic [DWIDTH-1:0]        bram_d,
  input  logic [DWIDTH-1:0]        bram_q
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [AWIDTH:0] MEM_LIM = (AWIDTH+1)'(MEM_SIZE);

  // Reject unsupported configurations at elaboration time.
  if (NREQ < 2 || NREQ > 8 || MAX_BURST < 1) begin : g_param_check
    $error("bram_port_arbiter: unsupported parameter set");
  end

  logic [AWIDTH-1:0] addr_arr [NREQ];
  logic [DWIDTH-1:0] d_arr    [NREQ];
  logic [NREQ-1:0]   win_onehot;

  logic [IDW-1:0]    ptr_reg;
  logic [IDW-1:0]    win;
  logic [IDW-1:0]    hi_idx;
  logic [IDW-1:0]    lo_idx;
  logic              hi_found;
  logic              any_req;
  logic              accept;
  logic              in_range;
  logic              lock;

  logic              ce_reg;
  logic              we_reg;
  logic [AWIDTH-1:0] addr_reg;
  logic [DWIDTH-1:0] d_reg;
  logic [NREQ-1:0]   err_reg;
  logic              tag1_v_reg;
  logic [IDW-1:0]    tag1_id_reg;
  logic              tag2_v_reg;
  logic [IDW-1:0]    tag2_id_reg;

  // Unpack the per-requester buses. Decode the one-hot winner and the read-return tag.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign addr_arr[gi]   = addr_in[gi*AWIDTH +: AWIDTH];
    assign d_arr[gi]      = d_in[gi*DWIDTH +: DWIDTH];
    assign win_onehot[gi] = (win == IDW'(gi));
    assign rvalid[gi]     = tag2_v_reg & (tag2_id_reg == IDW'(gi));
  end

`ifdef BRAM_ARB_BURST_LOCK_EN
  localparam int CW = $clog2(MAX_BURST + 1);
  logic [CW-1:0] burst_cnt_reg;
  logic [CW-1:0] burst_cnt_next;

  // The last winner keeps priority while it still requests and its run is below MAX_BURST.
  assign lock = (burst_cnt_reg != '0) && (burst_cnt_reg < CW'(MAX_BURST)) && req[ptr_reg];

  // Run length of consecutive accepts to the same requester. It restarts on a gap or a change.
  always_comb begin
    burst_cnt_next = '0;
    if (accept) begin
      burst_cnt_next = lock ? burst_cnt_reg + CW'(1) : CW'(1);
    end
  end

  // Burst counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt_reg <= '0;
    end else begin
      burst_cnt_reg <= burst_cnt_next;
    end
  end
`else
  assign lock = 1'b0;
`endif

  // Round-robin search. The first requester above ptr wins; otherwise the lowest requester wins.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_idx = IDW'(i);
        if (i > int'(ptr_reg)) begin
          hi_found = 1'b1;
          hi_idx   = IDW'(i);
        end
      end
    end
    any_req = |req;
    win     = hi_found ? hi_idx : lo_idx;
    if (lock) begin
      win = ptr_reg;
    end
  end

  assign gnt      = win_onehot & {NREQ{any_req & rst_n}};
  assign accept   = |(req & gnt);
  assign in_range = ({1'b0, addr_arr[win]} < MEM_LIM);

  // Issue the accepted access to the BRAM port and advance the read-tag pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg     <= IDW'(NREQ - 1);
      ce_reg      <= 1'b0;
      we_reg      <= 1'b0;
      addr_reg    <= '0;
      d_reg       <= '0;
      err_reg     <= '0;
      tag1_v_reg  <= 1'b0;
      tag1_id_reg <= '0;
      tag2_v_reg  <= 1'b0;
      tag2_id_reg <= '0;
    end else begin
      ce_reg      <= accept & in_range;
      we_reg      <= accept & in_range & we_in[win];
      err_reg     <= (accept && !in_range) ? gnt : '0;
      tag1_v_reg  <= accept & in_range & ~we_in[win];
      tag1_id_reg <= win;
      tag2_v_reg  <= tag1_v_reg;
      tag2_id_reg <= tag1_id_reg;
      if (accept) begin
        ptr_reg  <= win;
        addr_reg <= addr_arr[win];
        d_reg    <= d_arr[win];
      end
    end
  end

  assign bram_ce   = ce_reg;
  assign bram_we   = we_reg;
  assign bram_addr = addr_reg;
  assign bram_d    = d_reg;
  assign err       = err_reg;
  assign rdata     = tag2_v_reg ? bram_q : '0;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Testbench for bram_port_arbiter.
// It contains a behavioural BRAM and a scheduled-expectation model that is checked
// on every falling edge. Directed tests add literal checks.
module tb_bram_port_arbiter;

  localparam int NREQ      = 4;
  localparam int DWIDTH    = 8;
  localparam int AWIDTH    = 12;
  localparam int MEM_SIZE  = 3840;
  localparam int MAX_BURST = 4;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        we_in;
  logic [NREQ*AWIDTH-1:0] addr_in;
  logic [NREQ*DWIDTH-1:0] d_in;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        rvalid;
  logic [DWIDTH-1:0]      rdata;
  logic [NREQ-1:0]        err;
  logic [AWIDTH-1:0]      bram_addr;
  logic                   bram_ce;
  logic                   bram_we;
  logic [DWIDTH-1:0]      bram_d;
  logic [DWIDTH-1:0]      bram_q = '0;

  int n_checks = 0;
  int n_errors = 0;

  bram_port_arbiter #(
    .NREQ(NREQ), .DWIDTH(DWIDTH), .AWIDTH(AWIDTH),
    .MEM_SIZE(MEM_SIZE), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we_in(we_in), .addr_in(addr_in),
    .d_in(d_in), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .err(err),
    .bram_addr(bram_addr), .bram_ce(bram_ce), .bram_we(bram_we),
    .bram_d(bram_d), .bram_q(bram_q)
  );

  always #5 clk = ~clk;

  // External BRAM with a 1-cycle read latency.
  logic [DWIDTH-1:0] bram   [0:MEM_SIZE-1];
  // Contents of the memory as the model expects them.
  logic [DWIDTH-1:0] shadow [0:MEM_SIZE-1];

  always @(posedge clk) begin
    if (bram_ce) begin
      if (bram_we) bram[bram_addr] <= bram_d;
      else         bram_q <= bram[bram_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Model state: arbitration pointer, run length, and expected outputs scheduled per cycle.
  int               m_ptr = NREQ - 1;
  int               m_run = 0;
  int               cyc   = 0;
  logic             s_ce   [8];
  logic             s_we   [8];
  logic [AWIDTH-1:0] s_addr [8];
  logic [DWIDTH-1:0] s_d    [8];
  logic [NREQ-1:0]  s_err  [8];
  logic [NREQ-1:0]  s_rv   [8];
  logic [DWIDTH-1:0] s_rd   [8];

  always @(negedge clk) begin
    int slot, n1, n2, w;
    logic [AWIDTH-1:0] a;
    logic [DWIDTH-1:0] dv;
    logic [NREQ-1:0] oh;
    slot = cyc % 8;
    n1   = (cyc + 1) % 8;
    n2   = (cyc + 2) % 8;
    if (!rst_n) begin
      chk("rst_gnt", gnt, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_err", err, 0);
      chk("rst_ce", bram_ce, 0);
      chk("rst_we", bram_we, 0);
      chk("rst_addr", bram_addr, 0);
      chk("rst_d", bram_d, 0);
      m_ptr = NREQ - 1;
      m_run = 0;
      s_ce[n1] = 0; s_we[n1] = 0; s_err[n1] = '0; s_rv[n1] = '0;
      s_rv[n2] = '0;
    end else begin
      w = -1;
      for (int k = 1; k <= NREQ; k++) begin
        if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
      end
`ifdef BRAM_ARB_BURST_LOCK_EN
      if (m_run > 0 && m_run < MAX_BURST && req[m_ptr]) w = m_ptr;
`endif
      oh = (w >= 0) ? NREQ'(1 << w) : '0;
      chk("gnt", gnt, oh);
      chk("bram_ce", bram_ce, s_ce[slot]);
      chk("bram_we", bram_we, s_we[slot]);
      chk("err", err, s_err[slot]);
      chk("rvalid", rvalid, s_rv[slot]);
      if (s_rv[slot] != 0) chk("rdata", rdata, s_rd[slot]);
      if (s_ce[slot]) begin
        chk("bram_addr", bram_addr, s_addr[slot]);
        if (s_we[slot]) chk("bram_d", bram_d, s_d[slot]);
      end
      s_ce[n1] = 0; s_we[n1] = 0; s_err[n1] = '0; s_rv[n2] = '0;
      if (w >= 0) begin
        a  = addr_in[w*AWIDTH +: AWIDTH];
        dv = d_in[w*DWIDTH +: DWIDTH];
        if (a < MEM_SIZE) begin
          s_ce[n1] = 1; s_we[n1] = we_in[w]; s_addr[n1] = a; s_d[n1] = dv;
          if (we_in[w]) shadow[a] = dv;
          else begin s_rv[n2] = oh; s_rd[n2] = shadow[a]; end
        end else begin
          s_err[n1] = oh;
        end
        m_run = (w == m_ptr && m_run > 0 && m_run < MAX_BURST) ? m_run + 1 : 1;
        m_ptr = w;
      end else begin
        m_run = 0;
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic w, input logic [AWIDTH-1:0] a,
                       input logic [DWIDTH-1:0] d);
    req[i] = 1'b1;
    we_in[i] = w;
    addr_in[i*AWIDTH +: AWIDTH] = a;
    d_in[i*DWIDTH +: DWIDTH] = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  initial begin
    logic [DWIDTH-1:0] rd_tab [4];
    rd_tab[0] = 8'h12; rd_tab[1] = 8'h34; rd_tab[2] = 8'h56; rd_tab[3] = 8'h78;
    for (int i = 0; i < MEM_SIZE; i++) begin
      bram[i] = DWIDTH'(i * 7 + 3);
      shadow[i] = DWIDTH'(i * 7 + 3);
    end
    bram[12'h010] = 8'hA5; shadow[12'h010] = 8'hA5;
    for (int k = 0; k < 4; k++) begin
      bram[12'h100 + k] = rd_tab[k];
      shadow[12'h100 + k] = rd_tab[k];
    end
    rst_n = 1'b0; req = '0; we_in = '0; addr_in = '0; d_in = '0;
    tick(); tick();
    @(negedge clk);
    chk("lit_reset_gnt", gnt, 0);
    chk("lit_reset_ce", bram_ce, 0);
    rst_n = 1'b1;
    tick();

    // Single read of 0x010 by requester 0
    drive(0, 1'b0, 12'h010, 8'h00);
    @(negedge clk); chk("lit_t1_gnt", gnt, 4'b0001);
    tick(); req = '0;
    @(negedge clk); chk("lit_t1_ce", bram_ce, 1); chk("lit_t1_addr", bram_addr, 12'h010);
    tick();
    @(negedge clk); chk("lit_t1_rvalid", rvalid, 4'b0001); chk("lit_t1_rdata", rdata, 8'hA5);
    tick();
    $display("test1 single read done");

    // All four requesters read back-to-back
    do_reset();
    for (int k = 0; k < 4; k++) drive(k, 1'b0, AWIDTH'(12'h100 + k), 8'h00);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k < 4) chk("lit_t2_gnt", gnt, 32'(1 << k));
      if (k >= 2) begin
        chk("lit_t2_rvalid", rvalid, 32'(1 << (k - 2)));
        chk("lit_t2_rdata", rdata, rd_tab[k-2]);
      end
      tick();
      if (k == 3) req = '0;
    end
    $display("test2 round-robin reads done");

    // Write then read the same address
    drive(2, 1'b1, 12'h7FF, 8'h3C);
    @(negedge clk); chk("lit_t3_wgnt", gnt, 4'b0100);
    tick(); req = '0; drive(1, 1'b0, 12'h7FF, 8'h00);
    @(negedge clk); chk("lit_t3_rgnt", gnt, 4'b0010); chk("lit_t3_we", bram_we, 1);
    tick(); req = '0;
    tick();
    @(negedge clk); chk("lit_t3_rvalid", rvalid, 4'b0010); chk("lit_t3_rdata", rdata, 8'h3C);
    tick();
    $display("test3 write-read done");

    // Out-of-range access from requester 3
    drive(3, 1'b0, 12'hF00, 8'h00);
    @(negedge clk); chk("lit_t4_gnt", gnt, 4'b1000);
    tick(); req = '0;
    @(negedge clk); chk("lit_t4_ce", bram_ce, 0); chk("lit_t4_err", err, 4'b1000);
    tick();
    @(negedge clk); chk("lit_t4_err_end", err, 0); chk("lit_t4_rvalid", rvalid, 0);
    tick();
    @(negedge clk); chk("lit_t4_rvalid2", rvalid, 0);
    tick();
    $display("test4 range error done");

    // Reset while two reads are in flight
    drive(0, 1'b0, 12'h010, 8'h00); drive(1, 1'b0, 12'h100, 8'h00);
    @(negedge clk); chk("lit_t5_gnt0", gnt, 4'b0001);
    tick();
    @(negedge clk); chk("lit_t5_gnt1", gnt, 4'b0010);
    tick();
    rst_n = 1'b0; req = '0;
    @(negedge clk); chk("lit_t5_rvalid", rvalid, 0); chk("lit_t5_ce", bram_ce, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    for (int k = 0; k < 4; k++) drive(k, 1'b0, AWIDTH'(12'h100 + k), 8'h00);
    @(negedge clk); chk("lit_t5_first", gnt, 4'b0001);
    tick(); req = '0;
    tick(); tick();
    $display("test5 mid-op reset done");

    // Requesters 0 and 1 request continuously
    do_reset();
    drive(0, 1'b0, 12'h020, 8'h00); drive(1, 1'b0, 12'h021, 8'h00);
    for (int k = 0; k < 9; k++) begin
      int ew;
`ifdef BRAM_ARB_BURST_LOCK_EN
      ew = (k / MAX_BURST) % 2;
`else
      ew = k % 2;
`endif
      @(negedge clk); chk("lit_t6_gnt", gnt, 32'(1 << ew));
      tick();
    end
    req = '0;
    tick(); tick(); tick();
    $display("test6 continuous two-requester done");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
